// File: rtl/place_eval_if.sv
// place_eval_if -- bus between place_eval and its memories / controller.
//   start/busy/done     : evaluation handshake
//   re_edge/addr_edge   : shared read port of the edge ROMs (dout_ea, dout_eb)
//   re_pos/addr_pos     : shared read port of the pos_X/pos_Y RAMs (dout_px, dout_py)
//   total_cost, hop_cost, max_dist, err_count : evaluation results
// slave = place_eval, master = the surrounding controller / memories.
interface place_eval_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        re_edge;
  logic [31:0] addr_edge;
  logic [31:0] dout_ea;
  logic [31:0] dout_eb;
  logic        re_pos;
  logic [31:0] addr_pos;
  logic [31:0] dout_px;
  logic [31:0] dout_py;
  logic [31:0] total_cost;
  logic [31:0] hop_cost;
  logic [31:0] max_dist;
  logic [31:0] err_count;

  modport slave (
    input  start, dout_ea, dout_eb, dout_px, dout_py,
    output busy, done, re_edge, addr_edge, re_pos, addr_pos,
           total_cost, hop_cost, max_dist, err_count
  );

  modport master (
    output start, dout_ea, dout_eb, dout_px, dout_py,
    input  busy, done, re_edge, addr_edge, re_pos, addr_pos,
           total_cost, hop_cost, max_dist, err_count
  );
endinterface

// File: rtl/place_eval.sv
// place_eval -- walks N_EDGE edges of a placement on a GRID_N x GRID_N grid and
// accumulates wire cost, 1-hop cost, the largest edge distance and the number
// of invalid edges (off-grid/unplaced endpoint or two nodes on one site).
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : place_eval_if.slave (handshake, memory read ports, results)
// Build option: define PLACE_EVAL_CHEBYSHEV_EN to measure distance as
// max(dx,dy) instead of dx+dy. Timing and error rules do not change.
// Each edge takes 9 cycles: RD_E W_E RD_A W_A RD_B W_B CALC CALC ACC.
// CALC runs twice: first to capture the sink coordinates, then to register
// the derived distance/cost so ACC only adds.
module place_eval #(
  parameter int N_EDGE = 19,
  parameter int GRID_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  place_eval_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD_E, W_E, RD_A, W_A, RD_B, W_B, CALC, ACC, FIN
  } state_t;

  state_t state, nxt;

  logic        calc_ph;
  logic [31:0] idx;
  logic [31:0] eb_q;
  logic [31:0] xa, ya, xb, yb;
  logic        e_ok;
  logic [31:0] e_d, e_cost, e_hop;

  logic        busy_r, done_r, re_edge_r, re_pos_r;
  logic [31:0] addr_edge_r, addr_pos_r;
  logic [31:0] total_r, hop_r, maxd_r, err_r;

  // combinational edge metrics from the latched coordinates
  logic [31:0] sx, sy, dx, dy, d, cost, hop;
  logic        ok;

  function automatic logic in_grid(input logic [31:0] v);
    return ($signed(v) >= 0) && ($signed(v) < $signed(32'(GRID_N)));
  endfunction

  always_comb begin
    sx = xa - xb;
    sy = ya - yb;
    dx = sx[31] ? (32'd0 - sx) : sx;
    dy = sy[31] ? (32'd0 - sy) : sy;
`ifdef PLACE_EVAL_CHEBYSHEV_EN
    d    = ($signed(dx) > $signed(dy)) ? dx : dy;
    hop  = ((d + 32'd1) >> 1) - 32'd1;
`else
    d    = dx + dy;
    hop  = ((dx + 32'd1) >> 1) + ((dy + 32'd1) >> 1) - 32'd1;
`endif
    cost = d - 32'd1;
    ok   = in_grid(xa) && in_grid(ya) && in_grid(xb) && in_grid(yb) && (d != 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.start) nxt = RD_E;
      RD_E: nxt = (idx == 32'(N_EDGE)) ? FIN : W_E;
      W_E:  nxt = RD_A;
      RD_A: nxt = W_A;
      W_A:  nxt = RD_B;
      RD_B: nxt = W_B;
      W_B:  nxt = CALC;
      CALC: if (calc_ph) nxt = ACC;
      ACC:  nxt = RD_E;
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      calc_ph     <= 1'b0;
      idx         <= '0;
      eb_q        <= '0;
      xa          <= '0;
      ya          <= '0;
      xb          <= '0;
      yb          <= '0;
      e_ok        <= 1'b0;
      e_d         <= '0;
      e_cost      <= '0;
      e_hop       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      re_edge_r   <= 1'b0;
      re_pos_r    <= 1'b0;
      addr_edge_r <= '0;
      addr_pos_r  <= '0;
      total_r     <= '0;
      hop_r       <= '0;
      maxd_r      <= '0;
      err_r       <= '0;
    end else begin
      // read enables and done are single-cycle strobes
      re_edge_r <= 1'b0;
      re_pos_r  <= 1'b0;
      done_r    <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          busy_r  <= 1'b1;
          idx     <= '0;
          total_r <= '0;
          hop_r   <= '0;
          maxd_r  <= '0;
          err_r   <= '0;
        end
        RD_E: if (idx != 32'(N_EDGE)) begin
          re_edge_r   <= 1'b1;
          addr_edge_r <= idx;
        end
        RD_A: begin
          re_pos_r   <= 1'b1;
          addr_pos_r <= bus.dout_ea;
          eb_q       <= bus.dout_eb;
        end
        RD_B: begin
          xa         <= bus.dout_px;
          ya         <= bus.dout_py;
          re_pos_r   <= 1'b1;
          addr_pos_r <= eb_q;
        end
        CALC: begin
          calc_ph <= ~calc_ph;
          if (!calc_ph) begin
            xb <= bus.dout_px;
            yb <= bus.dout_py;
          end else begin
            e_ok   <= ok;
            e_d    <= d;
            e_cost <= cost;
            e_hop  <= hop;
          end
        end
        ACC: begin
          if (e_ok) begin
            total_r <= total_r + e_cost;
            hop_r   <= hop_r + e_hop;
            if ($signed(e_d) > $signed(maxd_r)) maxd_r <= e_d;
          end else begin
            err_r <= err_r + 32'd1;
          end
          idx <= idx + 32'd1;
        end
        FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.re_edge    = re_edge_r;
  assign bus.addr_edge  = addr_edge_r;
  assign bus.re_pos     = re_pos_r;
  assign bus.addr_pos   = addr_pos_r;
  assign bus.total_cost = total_r;
  assign bus.hop_cost   = hop_r;
  assign bus.max_dist   = maxd_r;
  assign bus.err_count  = err_r;

endmodule

// File: tb/tb_place_eval.sv
// tb_place_eval -- three instances of place_eval (N_EDGE = 0, 1, 2) on
// registered ROM/RAM models, driven with directed vectors.
module tb_place_eval;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]       st;
  logic [2:0]       dn, bz, rqe, rqp;
  logic [2:0][31:0] tc, hc, md, ec, ae, ap;

  logic [31:0] ea_rom [3][2];
  logic [31:0] eb_rom [3][2];
  logic [31:0] pos_x  [8];
  logic [31:0] pos_y  [8];

  int n_cmp = 0;
  int n_err = 0;

`ifdef PLACE_EVAL_CHEBYSHEV_EN
  localparam logic [31:0] X_TC = 32'd2, X_HC = 32'd1, X_MD = 32'd3;
`else
  localparam logic [31:0] X_TC = 32'd4, X_HC = 32'd2, X_MD = 32'd5;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    place_eval_if b();
    logic [31:0] ea_q, eb_q, px_q, py_q;

    place_eval #(.N_EDGE(g), .GRID_N(4)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
    );

    // memories sample re/addr on an edge and present dout until the next read
    always_ff @(posedge clk) begin
      if (b.re_edge) begin
        ea_q <= ea_rom[g][b.addr_edge[0]];
        eb_q <= eb_rom[g][b.addr_edge[0]];
      end
      if (b.re_pos) begin
        px_q <= pos_x[b.addr_pos[2:0]];
        py_q <= pos_y[b.addr_pos[2:0]];
      end
    end

    assign b.start   = st[g];
    assign b.dout_ea = ea_q;
    assign b.dout_eb = eb_q;
    assign b.dout_px = px_q;
    assign b.dout_py = py_q;
    assign dn[g]  = b.done;
    assign bz[g]  = b.busy;
    assign rqe[g] = b.re_edge;
    assign rqp[g] = b.re_pos;
    assign tc[g]  = b.total_cost;
    assign hc[g]  = b.hop_cost;
    assign md[g]  = b.max_dist;
    assign ec[g]  = b.err_count;
    assign ae[g]  = b.addr_edge;
    assign ap[g]  = b.addr_pos;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Pulse start on instance k; lat = clocks from the edge that sampled start
  // to done (-1 if none within the window); optionally re-pulse start at
  // edge restart_at while the instance is busy.
  task automatic run(input int k, input int restart_at, output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    @(posedge clk); #1 st[k] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      st[k] = (c == restart_at);
      if (dn[k]) begin
        pulses++;
        if (lat < 0) lat = c;
      end
    end
    st[k] = 1'b0;
  endtask

  int lat, pulses;

  initial begin
    st    = '0;
    reset = 1'b1;
    // nodes: 0(0,0) 1(3,2) 2(1,1) 3(1,2) 4(-1,0) 5(2,2) 6(2,2) 7(3,3)
    pos_x = '{32'd0, 32'd3, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd3};
    pos_y = '{32'd0, 32'd2, 32'd1, 32'd2, 32'd0,         32'd2, 32'd2, 32'd3};
    ea_rom[0][0] = 32'd0; eb_rom[0][0] = 32'd1;
    ea_rom[0][1] = 32'd0; eb_rom[0][1] = 32'd1;
    ea_rom[1][0] = 32'd0; eb_rom[1][0] = 32'd1;
    ea_rom[1][1] = 32'd0; eb_rom[1][1] = 32'd1;
    ea_rom[2][0] = 32'd2; eb_rom[2][0] = 32'd3;
    ea_rom[2][1] = 32'd2; eb_rom[2][1] = 32'd4;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), 32'(bz[k]), 32'd0);
      chk($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd0);
      chk($sformatf("rst_re%0d", k), 32'({rqe[k], rqp[k]}), 32'd0);
      chk($sformatf("rst_addr%0d", k), ae[k] | ap[k], 32'd0);
      chk($sformatf("rst_cost%0d", k), tc[k] | hc[k], 32'd0);
      chk($sformatf("rst_md_ec%0d", k), md[k] | ec[k], 32'd0);
    end
    reset = 1'b0;

    // single edge (0,0)-(3,2)
    run(1, -1, lat, pulses);
    chk("n1_lat", 32'(lat), 32'd11);
    chk("n1_pulses", 32'(pulses), 32'd1);
    chk("n1_total", tc[1], X_TC);
    chk("n1_hop", hc[1], X_HC);
    chk("n1_maxd", md[1], X_MD);
    chk("n1_err", ec[1], 32'd0);
    chk("n1_busy", 32'(bz[1]), 32'd0);
    chk("n1_addr_pos", ap[1], 32'd1);

    // valid unit edge followed by an edge with an unplaced sink
    run(2, -1, lat, pulses);
    chk("n2_lat", 32'(lat), 32'd20);
    chk("n2_total", tc[2], 32'd0);
    chk("n2_hop", hc[2], 32'd0);
    chk("n2_maxd", md[2], 32'd1);
    chk("n2_err", ec[2], 32'd1);
    chk("n2_addr_edge", ae[2], 32'd1);

    // empty edge list
    run(0, -1, lat, pulses);
    chk("n0_lat", 32'(lat), 32'd2);
    chk("n0_pulses", 32'(pulses), 32'd1);
    chk("n0_total", tc[0] | hc[0] | md[0] | ec[0], 32'd0);

    // collision edge (2,2)-(2,2) with a second start while busy
    ea_rom[1][0] = 32'd5; eb_rom[1][0] = 32'd6;
    run(1, 3, lat, pulses);
    chk("col_lat", 32'(lat), 32'd11);
    chk("col_pulses", 32'(pulses), 32'd1);
    chk("col_err", ec[1], 32'd1);
    chk("col_total", tc[1], 32'd0);
    chk("col_hop", hc[1], 32'd0);
    chk("col_maxd", md[1], 32'd0);

    // results hold after done
    repeat (3) @(posedge clk);
    #1 chk("hold_err", ec[1], 32'd1);
    chk("hold_maxd2", md[2], 32'd1);

    // reset 5 clocks into an evaluation
    ea_rom[1][0] = 32'd0; eb_rom[1][0] = 32'd1;
    @(posedge clk); #1 st[1] = 1'b1;
    @(posedge clk); #1 st[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("mid_busy_pre", 32'(bz[1]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_busy", 32'(bz[1]), 32'd0);
    chk("mid_re", 32'({rqe[1], rqp[1]}), 32'd0);
    chk("mid_addr", ae[1] | ap[1], 32'd0);
    chk("mid_res2", tc[2] | hc[2] | md[2] | ec[2], 32'd0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (dn[1]) pulses++;
    end
    chk("mid_no_done", 32'(pulses), 32'd0);
    chk("mid_res1", tc[1] | hc[1] | md[1] | ec[1], 32'd0);

    run(1, -1, lat, pulses);
    chk("re_lat", 32'(lat), 32'd11);
    chk("re_total", tc[1], X_TC);
    chk("re_hop", hc[1], X_HC);
    chk("re_maxd", md[1], X_MD);

    // reset and start on the same edge
    @(posedge clk); #1;
    st[0] = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    reset = 1'b0;
    chk("rst_vs_start", 32'(bz[0]), 32'd0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (dn[0]) pulses++;
    end
    chk("rst_vs_start_done", 32'(pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/place_eval.md
PLACE_EVAL -- requirements
Module: place_eval

Interface
REQ-001 Parameter N_EDGE, default 19, number of edges in the edge ROMs.
REQ-002 Parameter GRID_N, default 4, grid side length; valid coordinates are 0..GRID_N-1.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to evaluate the current placement.
REQ-006 busy  output  1  high from accepted start until done.
REQ-007 done  output  1  one-cycle pulse when results are final.
REQ-008 re_edge  output  1  read enable, shared by both edge ROMs.
REQ-009 addr_edge  output  32  edge index, shared by both edge ROMs.
REQ-010 dout_ea, dout_eb  input  32 each  signed source and sink node ids.
REQ-011 re_pos  output  1  read enable, shared by the pos_X and pos_Y RAMs.
REQ-012 addr_pos  output  32  node id.
REQ-013 dout_px, dout_py  input  32 each  signed node coordinates; -1 means unplaced.
REQ-014 total_cost  output  32  signed sum of edge costs.
REQ-015 hop_cost  output  32  signed sum of 1-hop edge costs.
REQ-016 max_dist  output  32  largest edge distance seen.
REQ-017 err_count  output  32  number of invalid edges.

Function
REQ-018 The block drives all memory controls as registered outputs; re and addr are high for exactly one cycle per read.
REQ-019 The memory samples re/addr at edge E; the block samples dout at edge E+1.
REQ-020 FSM states: IDLE, RD_E, W_E, RD_A, W_A, RD_B, W_B, CALC, ACC, FIN.
REQ-021 IDLE to RD_E on start; start also clears the accumulators and sets the edge index i=0.
REQ-022 RD_E: if i==N_EDGE go to FIN; otherwise issue the edge read at i.
REQ-023 RD_A issues a position read at dout_ea; RD_B latches xa,ya and issues a position read at dout_eb.
REQ-024 CALC latches xb,yb, then computes dx=|xa-xb| and dy=|ya-yb| as 32-bit two's complement values.
REQ-025 Edge distance d=dx+dy; cost=d-1; hop=ceil(dx/2)+ceil(dy/2)-1.
REQ-026 ACC adds cost and hop to the accumulators and updates max_dist=max(max_dist,d).
REQ-027 ACC then sets i=i+1 and returns to RD_E.
REQ-028 Each edge takes exactly 9 clock cycles.
REQ-029 done rises exactly 9*N_EDGE+2 clocks after the edge that sampled start.
REQ-030 FIN pulses done, clears busy, and returns to IDLE.
REQ-031 An edge is invalid if any coordinate is <0 or >=GRID_N.
REQ-032 An edge is also invalid if d==0 (node collision).
REQ-033 An invalid edge increments err_count and leaves cost, hop and max_dist unchanged.
REQ-034 start while busy is ignored.
REQ-035 Outputs hold their final values after done until the next accepted start.
REQ-036 N_EDGE=0: done two clocks after start, all results 0.

Reset
REQ-037 On reset, busy, done, re_edge and re_pos are 0.
REQ-038 On reset, addr_edge, addr_pos, total_cost, hop_cost, max_dist and err_count are 0, and the FSM is in IDLE.
REQ-039 Reset mid-evaluation aborts immediately, with no done pulse.
REQ-040 Reset wins over a simultaneous start.

Configuration
REQ-041 With PLACE_EVAL_CHEBYSHEV_EN defined, d=max(dx,dy), cost=d-1 and hop=ceil(d/2)-1.
REQ-042 With PLACE_EVAL_CHEBYSHEV_EN undefined, the Manhattan rules of REQ-025 apply.
REQ-043 Timing and error rules are identical in both builds.

Verification
REQ-044 N_EDGE=1, a=(0,0), b=(3,2), Manhattan build -> total_cost=4, hop_cost=2, max_dist=5, err_count=0, done at 11 clocks.
REQ-045 Same stimulus with PLACE_EVAL_CHEBYSHEV_EN -> total_cost=2, hop_cost=1, max_dist=3.
REQ-046 N_EDGE=2: edge0 a=(1,1), b=(1,2); edge1 with b x=-1 -> total_cost=0, hop_cost=0, max_dist=1, err_count=1.
REQ-047 Two nodes both at (2,2) -> err_count=1 and sums unchanged; a second start while busy -> exactly one done pulse.
REQ-048 Reset asserted 5 clocks after start -> no done, all outputs 0; a fresh start then gives the correct results.
